// File: rtl/prbs_pkg.sv
// prbs_pkg: shared types and helpers for the parallel PRBS generator/checker.
// Sync FSM encodings, constant clog2 and a 64-bit popcount.
package prbs_pkg;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } prbs_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic logic [6:0] popcount(input logic [63:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) begin
            n = n + 7'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/prbs_par_lfsr.sv
// prbs_par_lfsr: combinational NBITS-step unroll of an x^L + x^T + 1 LFSR.
// Generator mode feeds back its own output; checker mode shifts in received bits.
module prbs_par_lfsr #(
    parameter int L        = 23,
    parameter int T        = 18,
    parameter int NBITS    = 8,
    parameter int CHK_MODE = 0
) (
    input  logic [L-1:0]     state,
    input  logic [NBITS-1:0] din,
    output logic [L-1:0]     state_nxt,
    output logic [NBITS-1:0] dout
);

    logic [L-1:0] s;
    logic         b;
    logic         fb;

    // Unroll NBITS serial steps; bit 0 is the earliest step.
    always_comb begin
        s    = state;
        b    = 1'b0;
        fb   = 1'b0;
        dout = '0;
        for (int i = 0; i < NBITS; i++) begin
            b       = s[L-1] ^ s[T-1];
            fb      = (CHK_MODE != 0) ? din[i] : b;
            dout[i] = (CHK_MODE != 0) ? (din[i] ^ b) : b;
            s       = {s[L-2:0], fb};
        end
        state_nxt = s;
    end

endmodule

// File: rtl/prbs_gen_chk_par.sv
// prbs_gen_chk_par: word-parallel PRBS generator and self-synchronising checker.
// Checker runs a HUNT/LOCKED sync FSM and a saturating bit-error counter.
module prbs_gen_chk_par
    import prbs_pkg::*;
#(
    parameter int POLY_LENGTH = 23,
    parameter int POLY_TAP    = 18,
    parameter int NBITS       = 8,
    parameter int INV_PATTERN = 1,
    parameter int LOCK_CNT    = 16,
    parameter int UNLOCK_CNT  = 4,
    parameter int CNT_W       = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             GEN_EN,
    input  logic             INJ_ERR,
    output logic [NBITS-1:0] GEN_DATA,
    output logic             GEN_VALID,
    input  logic [NBITS-1:0] CHK_DATA,
    input  logic             CHK_VALID,
    input  logic             CLR_CNT,
    output logic [NBITS-1:0] ERR_VEC,
    output logic             ERR_DETECT,
    output logic             ERR_VALID,
    output logic             LOCKED,
    output logic [CNT_W-1:0] ERR_CNT
);

    localparam int L  = POLY_LENGTH;
    localparam int GW = clog2(LOCK_CNT + 1);
    localparam int BW = clog2(UNLOCK_CNT + 1);
    localparam int SW = CNT_W + 8;

    localparam logic [NBITS-1:0] INV_MASK =
        (INV_PATTERN != 0) ? {NBITS{1'b1}} : {NBITS{1'b0}};

    logic [L-1:0]     gen_s;
    logic [L-1:0]     gen_s_nxt;
    logic [NBITS-1:0] gen_bits;
    logic [L-1:0]     chk_s;
    logic [L-1:0]     chk_s_nxt;
    logic [NBITS-1:0] chk_r;
    logic [NBITS-1:0] chk_e_raw;
    logic [NBITS-1:0] chk_e;
    logic             err_any;
    logic [6:0]       err_pc;
    logic [SW-1:0]    cnt_sum;
    logic [CNT_W-1:0] cnt_sat;

    prbs_state_e      state;
    logic [GW-1:0]    good_run;
    logic [BW-1:0]    bad_run;

    prbs_par_lfsr #(
        .L        (L),
        .T        (POLY_TAP),
        .NBITS    (NBITS),
        .CHK_MODE (0)
    ) u_gen (
        .state     (gen_s),
        .din       ({NBITS{1'b0}}),
        .state_nxt (gen_s_nxt),
        .dout      (gen_bits)
    );

    prbs_par_lfsr #(
        .L        (L),
        .T        (POLY_TAP),
        .NBITS    (NBITS),
        .CHK_MODE (1)
    ) u_chk (
        .state     (chk_s),
        .din       (chk_r),
        .state_nxt (chk_s_nxt),
        .dout      (chk_e_raw)
    );

    assign chk_r   = CHK_DATA ^ INV_MASK;
    // All-zero state is the lockup pattern and never a valid sequence.
    assign chk_e   = (chk_s == '0) ? {NBITS{1'b1}} : chk_e_raw;
    assign err_any = |chk_e;
    assign err_pc  = popcount(64'(chk_e));
    assign cnt_sum = SW'(ERR_CNT) + SW'(err_pc);
    assign cnt_sat = (|cnt_sum[SW-1:CNT_W]) ? {CNT_W{1'b1}}
                                            : cnt_sum[CNT_W-1:0];
    assign LOCKED  = (state == ST_LOCKED);

    // Generator: advance one word per enabled cycle, inject on bit 0 only.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            gen_s     <= '1;
            GEN_DATA  <= '0;
            GEN_VALID <= 1'b0;
        end else begin
            GEN_VALID <= GEN_EN;
            if (GEN_EN) begin
                gen_s    <= gen_s_nxt;
                GEN_DATA <= gen_bits ^ INV_MASK ^ NBITS'(INJ_ERR);
            end
        end
    end

    // Checker datapath: self-synchronising state and per-bit error flags.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            chk_s      <= '1;
            ERR_VEC    <= '0;
            ERR_VALID  <= 1'b0;
            ERR_DETECT <= 1'b0;
        end else begin
            ERR_VALID  <= CHK_VALID;
            ERR_DETECT <= CHK_VALID & err_any;
            if (CHK_VALID) begin
                chk_s   <= chk_s_nxt;
                ERR_VEC <= chk_e;
            end
        end
    end

    // Sync FSM: count clean words to lock, errored words to unlock.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= ST_HUNT;
            good_run <= '0;
            bad_run  <= '0;
        end else if (CHK_VALID) begin
            unique case (state)
                ST_HUNT: begin
                    if (err_any) begin
                        good_run <= '0;
                    end else if (good_run == GW'(LOCK_CNT - 1)) begin
                        state    <= ST_LOCKED;
                        good_run <= GW'(LOCK_CNT);
                        bad_run  <= '0;
                    end else begin
                        good_run <= good_run + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (!err_any) begin
                        bad_run <= '0;
                    end else if (bad_run == BW'(UNLOCK_CNT - 1)) begin
                        state    <= ST_HUNT;
                        bad_run  <= BW'(UNLOCK_CNT);
                        good_run <= '0;
                    end else begin
                        bad_run <= bad_run + 1'b1;
                    end
                end
            endcase
        end
    end

    // Error counter: saturating, only while locked, clear has priority.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ERR_CNT <= '0;
        end else if (CLR_CNT) begin
            ERR_CNT <= '0;
        end else if (CHK_VALID && state == ST_LOCKED) begin
            ERR_CNT <= cnt_sat;
        end
    end

endmodule

// File: doc/prbs_gen_chk_par.md
Name: prbs_gen_chk_par

Overview:
Parametrised word-parallel PRBS generator plus self-synchronising checker, one instance per serial lane.
- Generator emits NBITS PRBS bits per enabled cycle.
- Checker accepts NBITS bits per valid cycle, reports a per-bit error vector, runs a HUNT/LOCKED sync FSM and keeps a saturating bit-error counter.
- Used for link BIST on SERDES/parallel data paths. Supersedes fixed-width single-rate generator/checker tops.

Parameters:
POLY_LENGTH, 23, LFSR length L (polynomial x^L + x^T + 1), 3..31
POLY_TAP, 18, tap T, 1 <= T < L
NBITS, 8, parallel word width, 1..64
INV_PATTERN, 1, 1 = generated and expected data inverted on the wire
LOCK_CNT, 16, consecutive error-free words needed to enter LOCKED, >= 1
UNLOCK_CNT, 4, consecutive errored words needed to leave LOCKED, >= 1
CNT_W, 32, error counter width

Ports:
CLK  in  1  clock
RST_N  in  1  synchronous reset, active low
GEN_EN  in  1  advance generator by one word
INJ_ERR  in  1  sampled with GEN_EN; flips bit 0 of that generated word
GEN_DATA  out  NBITS  generated word, bit 0 earliest in time
GEN_VALID  out  1  GEN_DATA valid
CHK_DATA  in  NBITS  received word, bit 0 earliest in time
CHK_VALID  in  1  CHK_DATA valid
CLR_CNT  in  1  synchronous clear of ERR_CNT
ERR_VEC  out  NBITS  per-bit error flags of last checked word
ERR_DETECT  out  1  OR of ERR_VEC, qualified by ERR_VALID
ERR_VALID  out  1  ERR_VEC valid
LOCKED  out  1  checker in LOCKED state
ERR_CNT  out  CNT_W  saturating count of bit errors while LOCKED

Behaviour:
- Reset (RST_N=0 at a CLK edge): both LFSR states = all ones. GEN_DATA=0, GEN_VALID=0, ERR_VEC=0, ERR_VALID=0, ERR_DETECT=0, LOCKED=0, FSM=HUNT, run counters=0, ERR_CNT=0. Reset mid-operation behaves identically and discards any in-flight word.
- LFSR serial step, state s[L-1:0]:
  - b = s[L-1] ^ s[T-1]; s <= {s[L-2:0], b}.
  - Generator emits b (XOR INV_PATTERN).
  - One word = NBITS unrolled steps in one cycle; bit i of the word is step i.
- Generator: GEN_EN=1 -> next edge GEN_DATA = new word (bit 0 XOR INJ_ERR), GEN_VALID=1. GEN_EN=0 -> GEN_VALID=0, state and GEN_DATA held. Latency 1 cycle. Injection never alters LFSR state.
- Checker, per step:
  - r = received bit XOR INV_PATTERN.
  - e = r ^ s[L-1] ^ s[T-1].
  - s <= {s[L-2:0], r} (self-synchronising).
  - Processed only when CHK_VALID=1; state frozen otherwise.
- Stuck detect: if checker state is all zeros before the word, all NBITS bits are flagged as errors (lockup pattern is never valid).
- Outputs, latency 1: the edge after CHK_VALID=1 sets ERR_VEC = e bits, ERR_VALID=1, ERR_DETECT = |e. CHK_VALID=0 -> ERR_VALID=0, ERR_DETECT=0, ERR_VEC held.
- Single-bit line error yields 3 flagged bits: positions i, i+T, i+L, possibly spanning words.
- FSM, updated on each valid word, LOCKED registered in the same cycle as ERR_VEC:
  - HUNT: a clean word increments good_run, an errored word clears it. good_run reaching LOCK_CNT -> LOCKED, bad_run=0.
  - LOCKED: an errored word increments bad_run, a clean word clears it. bad_run reaching UNLOCK_CNT -> HUNT, good_run=0.
- ERR_CNT:
  - Adds popcount(e) for every valid word processed while the FSM is LOCKED before the update, including the word causing LOCKED->HUNT.
  - Saturates at 2^CNT_W-1, no wrap.
  - CLR_CNT=1 -> 0 next edge; CLR_CNT wins over a simultaneous increment (that word's errors are dropped).
- Run counters saturate at their thresholds; widths are clog2(threshold+1).

Decomposition:
- Shared package/include prbs_pkg: FSM state encodings ST_HUNT/ST_LOCKED, clog2 and popcount functions.
- Sub-module prbs_par_lfsr (params L, T, NBITS, CHK_MODE): combinational NBITS-step unroll returning next state and output/error bits. Instantiated once in generator mode, once in checker mode; all registers stay in the top.

Test Plan:
1. L=7, T=6, NBITS=8, INV_PATTERN=0, reset then GEN_EN=1 -> first GEN_DATA=0x40, period 127 bits. With INV_PATTERN=1 -> first word 0xBF.
2. Loopback GEN->CHK, LOCK_CNT=16 -> LOCKED=1 within 18 words of the first valid word. ERR_CNT=0 after 10000 words. ERR_VALID gaps (CHK_VALID toggled, data held) -> no errors.
3. Locked, one INJ_ERR pulse -> flagged bits at offsets 0, 6, 7 from the injected bit. ERR_CNT=3. LOCKED stays 1.
4. Locked, CHK_DATA forced 0x00 -> ERR_VEC=0xFF from the stuck state onward. LOCKED=0 after 4 errored words. ERR_CNT frozen afterwards.
5. CNT_W=8, random CHK_DATA forced into LOCKED state -> ERR_CNT saturates at 255. CLR_CNT with a simultaneous errored word -> ERR_CNT=0.
6. RST_N low 1 cycle while locked -> next edge LOCKED=0, ERR_CNT=0, GEN_VALID=0. First word after restart = 0x40.
